// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// master drives the request side, slave is the arithmetic block.
interface serial_add_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cb_out;
   logic             ovf;

   modport master (
      output start, mode, a, b,
      input  busy, done, result, cb_out, ovf
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, result, cb_out, ovf
   );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, with a
// registered carry/borrow; result, carry/borrow-out and signed overflow are flopped.
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_add_sub_if.slave   io
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, a_sh_next;
   logic [WIDTH-1:0] b_sh_reg, b_sh_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             mode_reg, mode_next;
   logic             c_reg, c_next;
   logic             a_msb_reg, a_msb_next;
   logic             b_msb_reg, b_msb_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             cb_reg, cb_next;
   logic             ovf_reg, ovf_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   logic bit_x, bit_y, sum_bit, carry_bit;

   assign bit_x     = a_sh_reg[0];
   assign bit_y     = b_sh_reg[0];
   assign sum_bit   = bit_x ^ bit_y ^ c_reg;
   assign carry_bit = mode_reg ? ((~bit_x & bit_y) | (~(bit_x ^ bit_y) & c_reg))
                               : ((bit_x & bit_y) | (c_reg & (bit_x ^ bit_y)));

   always_comb begin
      state_next  = state_reg;
      a_sh_next   = a_sh_reg;
      b_sh_next   = b_sh_reg;
      acc_next    = acc_reg;
      cnt_next    = cnt_reg;
      mode_next   = mode_reg;
      c_next      = c_reg;
      a_msb_next  = a_msb_reg;
      b_msb_next  = b_msb_reg;
      result_next = result_reg;
      cb_next     = cb_reg;
      ovf_next    = ovf_reg;
      busy_next   = busy_reg;
      done_next   = done_reg;
      case (state_reg)
         IDLE: begin
            if (io.start) begin
               state_next = RUN;
               a_sh_next  = io.a;
               b_sh_next  = io.b;
               mode_next  = io.mode;
               // Operand MSBs are kept because the shift registers lose them.
               a_msb_next = io.a[WIDTH-1];
               b_msb_next = io.b[WIDTH-1];
               acc_next   = '0;
               cnt_next   = '0;
               c_next     = 1'b0;
               busy_next  = 1'b1;
            end
         end
         RUN: begin
            a_sh_next = a_sh_reg >> 1;
            b_sh_next = b_sh_reg >> 1;
            acc_next  = {sum_bit, acc_reg[WIDTH-1:1]};
            c_next    = carry_bit;
            cnt_next  = cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
               state_next  = DONE;
               busy_next   = 1'b0;
               done_next   = 1'b1;
               result_next = {sum_bit, acc_reg[WIDTH-1:1]};
               cb_next     = carry_bit;
               ovf_next    = mode_reg ? ((a_msb_reg ^ b_msb_reg) & (sum_bit ^ a_msb_reg))
                                      : (~(a_msb_reg ^ b_msb_reg) & (sum_bit ^ a_msb_reg));
            end
         end
         DONE: begin
            state_next = IDLE;
            done_next  = 1'b0;
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         mode_reg   <= 1'b0;
         c_reg      <= 1'b0;
         a_msb_reg  <= 1'b0;
         b_msb_reg  <= 1'b0;
         result_reg <= '0;
         cb_reg     <= 1'b0;
         ovf_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         a_sh_reg   <= a_sh_next;
         b_sh_reg   <= b_sh_next;
         acc_reg    <= acc_next;
         cnt_reg    <= cnt_next;
         mode_reg   <= mode_next;
         c_reg      <= c_next;
         a_msb_reg  <= a_msb_next;
         b_msb_reg  <= b_msb_next;
         result_reg <= result_next;
         cb_reg     <= cb_next;
         ovf_reg    <= ovf_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   assign io.busy   = busy_reg;
   assign io.done   = done_reg;
   assign io.result = result_reg;
   assign io.cb_out = cb_reg;
   assign io.ovf    = ovf_reg;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub at WIDTH 8, 2 and 16 against an arithmetic reference
// model; a single compare process checks every instance on every falling edge.
module tb_serial_add_sub;
   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        start_drv [N];
   logic        mode_drv  [N];
   logic [63:0] a_drv     [N];
   logic [63:0] b_drv     [N];
   logic        busy_obs  [N];
   logic        done_obs  [N];
   logic        cb_obs    [N];
   logic        ovf_obs   [N];
   logic [63:0] res_obs   [N];

   function automatic int wid(input int i);
      return (i == 0) ? 8 : (i == 1) ? 2 : 16;
   endfunction

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         localparam int W = (gi == 0) ? 8 : (gi == 1) ? 2 : 16;
         serial_add_sub_if #(.WIDTH(W)) bus ();
         assign bus.start = start_drv[gi];
         assign bus.mode  = mode_drv[gi];
         assign bus.a     = a_drv[gi][W-1:0];
         assign bus.b     = b_drv[gi][W-1:0];
         assign busy_obs[gi] = bus.busy;
         assign done_obs[gi] = bus.done;
         assign cb_obs[gi]   = bus.cb_out;
         assign ovf_obs[gi]  = bus.ovf;
         assign res_obs[gi]  = 64'(bus.result);
         serial_add_sub #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .io    (bus.slave)
         );
      end
   endgenerate

   // Reference: plain unsigned and signed arithmetic on the operand values.
   function automatic void model(input int w, input longint unsigned a_in, input longint unsigned b_in,
                                 input bit m, output longint unsigned r, output bit cb, output bit ov);
      longint unsigned mask, a, b;
      longint signed   half, sa, sb, sres;
      mask = (64'd1 << w) - 64'd1;
      a    = a_in & mask;
      b    = b_in & mask;
      half = longint'(64'd1 << (w - 1));
      if (m) begin
         r  = (a - b) & mask;
         cb = (a < b);
      end else begin
         r  = (a + b) & mask;
         cb = (((a + b) >> w) & 64'd1) != 0;
      end
      sa = longint'(a);
      sb = longint'(b);
      if (sa >= half) sa = sa - 2 * half;
      if (sb >= half) sb = sb - 2 * half;
      sres = m ? (sa - sb) : (sa + sb);
      ov   = (sres >= half) || (sres < -half);
   endfunction

   int tests = 0;
   int fails = 0;
   int launched [N];
   int completed[N];
   longint unsigned exp_res[N];
   bit              exp_cb [N];
   bit              exp_ovf[N];
   longint unsigned held_res[N];
   bit              held_cb [N];
   bit              held_ovf[N];
   int              busy_cnt[N];
   int              age     [N];
   bit              prev_done[N];

   task automatic check_out(input string nm, input int i, input longint unsigned er, input bit ec, input bit eo);
      tests++;
      if (res_obs[i] != er || cb_obs[i] != ec || ovf_obs[i] != eo) begin
         fails++;
         $display("FAIL %s w%0d: got result=%0h cb=%b ovf=%b, need result=%0h cb=%b ovf=%b",
                  nm, wid(i), res_obs[i], cb_obs[i], ovf_obs[i], er, ec, eo);
      end
   endtask

   task automatic check_flag(input string nm, input int i, input bit ok, input int got, input int need);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s w%0d: got %0d, need %0d", nm, wid(i), got, need);
      end
   endtask

   task automatic pin(input int w, input longint unsigned a, input longint unsigned b, input bit m,
                      input longint unsigned er, input bit ec, input bit eo);
      longint unsigned r;
      bit c, o;
      model(w, a, b, m, r, c, o);
      tests++;
      if (r != er || c != ec || o != eo) begin
         fails++;
         $display("FAIL model_pin w%0d a=%0h b=%0h m=%b: got %0h/%b/%b, need %0h/%b/%b",
                  w, a, b, m, r, c, o, er, ec, eo);
      end
   endtask

   // Compare process.
   initial begin
      for (int i = 0; i < N; i++) begin
         completed[i] = 0; held_res[i] = 0; held_cb[i] = 0; held_ovf[i] = 0;
         busy_cnt[i] = 0; age[i] = 0; prev_done[i] = 0;
      end
      pin(8, 64'h7F, 64'h01, 1'b0, 64'h80, 1'b0, 1'b1);
      pin(8, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 1'b0);
      pin(8, 64'h03, 64'h05, 1'b1, 64'hFE, 1'b1, 1'b0);
      pin(8, 64'h80, 64'h01, 1'b1, 64'h7F, 1'b0, 1'b1);
      pin(2, 64'h1,  64'h1,  1'b0, 64'h2,  1'b0, 1'b1);
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
               check_out("reset_out", i, 64'd0, 1'b0, 1'b0);
               check_flag("reset_busy_done", i, !busy_obs[i] && !done_obs[i],
                          int'(busy_obs[i]) + int'(done_obs[i]), 0);
               held_res[i] = 0; held_cb[i] = 0; held_ovf[i] = 0;
               busy_cnt[i] = 0; age[i] = 0; prev_done[i] = 0;
               completed[i] = launched[i];
            end else begin
               check_flag("busy_and_done", i, !(busy_obs[i] && done_obs[i]), int'(busy_obs[i] && done_obs[i]), 0);
               if (busy_obs[i]) begin
                  busy_cnt[i]++;
                  check_flag("busy_while_idle", i, completed[i] != launched[i], 1, 0);
               end
               if (done_obs[i]) begin
                  check_flag("done_width", i, !prev_done[i], 2, 1);
                  check_flag("spurious_done", i, completed[i] != launched[i], 1, 0);
                  if (completed[i] != launched[i]) begin
                     check_out("result", i, exp_res[i], exp_cb[i], exp_ovf[i]);
                     check_flag("latency", i, busy_cnt[i] == wid(i), busy_cnt[i], wid(i));
                     $display("[TB] w%0d done: result=%0h cb=%b ovf=%b latency=%0d",
                              wid(i), res_obs[i], cb_obs[i], ovf_obs[i], busy_cnt[i]);
                     held_res[i] = exp_res[i]; held_cb[i] = exp_cb[i]; held_ovf[i] = exp_ovf[i];
                     completed[i]++;
                  end
                  busy_cnt[i] = 0;
                  age[i] = 0;
               end else begin
                  check_out("hold", i, held_res[i], held_cb[i], held_ovf[i]);
                  if (completed[i] != launched[i]) begin
                     age[i]++;
                     if (age[i] > wid(i) + 4) begin
                        check_flag("done_timeout", i, 1'b0, age[i], wid(i));
                        completed[i] = launched[i];
                        age[i] = 0;
                     end
                  end
               end
               prev_done[i] = done_obs[i];
            end
         end
      end
   end

   task automatic launch(input int i, input logic [63:0] a, input logic [63:0] b, input logic m);
      longint unsigned r;
      bit c, o;
      @(posedge clk); #1;
      model(wid(i), a, b, m, r, c, o);
      exp_res[i] = r; exp_cb[i] = c; exp_ovf[i] = o;
      a_drv[i] = a; b_drv[i] = b; mode_drv[i] = m; start_drv[i] = 1'b1;
      launched[i]++;
      @(posedge clk); #1;
      start_drv[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (completed[i] == launched[i]) break;
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         start_drv[i] = 1'b0; mode_drv[i] = 1'b0; a_drv[i] = '0; b_drv[i] = '0; launched[i] = 0;
      end
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      launch(0, 64'h7F, 64'h01, 1'b0);
      wait_idle(0);

      // Reset during the third RUN cycle discards the operation.
      launch(0, 64'hFF, 64'h01, 1'b0);
      @(posedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);

      launch(0, 64'hFF, 64'h01, 1'b0); wait_idle(0);
      launch(0, 64'h03, 64'h05, 1'b1); wait_idle(0);
      launch(0, 64'h80, 64'h01, 1'b1); wait_idle(0);

      // New requests and operand changes during RUN and DONE must be ignored.
      launch(0, 64'h12, 64'h34, 1'b0);
      for (int k = 0; k < 4; k++) begin
         a_drv[0] = 64'($urandom); b_drv[0] = 64'($urandom);
         mode_drv[0] = ~mode_drv[0]; start_drv[0] = 1'b1;
         @(posedge clk); #1;
      end
      start_drv[0] = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done_obs[0]) break;
      end
      a_drv[0] = 64'h55; b_drv[0] = 64'h66; start_drv[0] = 1'b1;
      @(posedge clk); #1 start_drv[0] = 1'b0;
      repeat (14) @(posedge clk);

      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int m = 0; m < 2; m++) begin
               launch(1, 64'(a), 64'(b), m[0]);
               wait_idle(1);
            end

      for (int k = 0; k < 1000; k++) begin
         launch(2, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));
         wait_idle(2);
      end

      for (int k = 0; k < 100; k++) begin
         launch(0, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));
         wait_idle(0);
      end

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
